// File: rtl/sct_pkg.sv
// Shared types and constants for the sct stimulus sequencer: FSM states,
// the a..s bit positions of the 19-bit vector and the vector packing helper.
package sct_pkg;

    localparam int unsigned CNT_W = 8;
    localparam int unsigned ACT_W = 16;
    localparam int unsigned VEC_W = 19;
    localparam int unsigned CFG_W = 11;
    localparam int unsigned REM_W = 9;

    localparam int unsigned A_IDX   = 0;
    localparam int unsigned B_IDX   = 1;
    localparam int unsigned C_IDX   = 2;
    localparam int unsigned D_IDX   = 3;
    localparam int unsigned E_IDX   = 4;
    localparam int unsigned F_IDX   = 5;
    localparam int unsigned CNT_LSB = 6;
    localparam int unsigned G_IDX   = 6;
    localparam int unsigned H_IDX   = 7;
    localparam int unsigned I_IDX   = 8;
    localparam int unsigned J_IDX   = 9;
    localparam int unsigned K_IDX   = 10;
    localparam int unsigned L_IDX   = 11;
    localparam int unsigned M_IDX   = 12;
    localparam int unsigned N_IDX   = 13;
    localparam int unsigned O_IDX   = 14;
    localparam int unsigned P_IDX   = 15;
    localparam int unsigned Q_IDX   = 16;
    localparam int unsigned R_IDX   = 17;
    localparam int unsigned S_IDX   = 18;

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    // Places the count field on g..n between the static a..f and o..s bits.
    function automatic logic [VEC_W-1:0] pack_vec(input logic [CFG_W-1:0] cfg,
                                                  input logic [CNT_W-1:0] cnt);
        return {cfg[CFG_W-1:CNT_LSB], cnt, cfg[CNT_LSB-1:0]};
    endfunction

endpackage

// File: rtl/sct_toggle_cnt.sv
// Saturating Hamming-distance accumulator over successive accepted vectors
// of one run; built into sct_stim_seq only when SCT_ACT_CNT_EN is defined.
module sct_toggle_cnt
    import sct_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             acc,
    input  logic [VEC_W-1:0] vec,
    output logic [ACT_W-1:0] act_cnt
);

    localparam int unsigned POP_W = 5;
    localparam int unsigned SUM_W = ACT_W + 1;

    logic [VEC_W-1:0] prev;
    logic             have_prev;
    logic [POP_W-1:0] pop_c;
    logic [SUM_W-1:0] sum_c;

    always_comb begin
        pop_c = '0;
        for (int i = 0; i < VEC_W; i++) begin
            pop_c = pop_c + POP_W'(vec[i] ^ prev[i]);
        end
    end

    assign sum_c = SUM_W'(act_cnt) + SUM_W'(pop_c);

    // The first accepted vector of a run only seeds prev.
    always_ff @(posedge clk) begin
        if (rst) begin
            act_cnt   <= '0;
            prev      <= '0;
            have_prev <= 1'b0;
        end else if (clr) begin
            act_cnt   <= '0;
            have_prev <= 1'b0;
        end else if (acc) begin
            prev      <= vec;
            have_prev <= 1'b1;
            if (have_prev) begin
                act_cnt <= sum_c[ACT_W] ? '1 : sum_c[ACT_W-1:0];
            end
        end
    end

endmodule

// File: rtl/sct_stim_seq.sv
// Stimulus sequencer feeding sct: steps an 8-bit count on g..n once per accepted
// vector over valid/ready. Define SCT_ACT_CNT_EN to add the act_cnt toggle counter.
module sct_stim_seq
    import sct_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] seed,
    input  logic [7:0]       len,
    input  logic [CFG_W-1:0] ctrl,
    output logic             busy,
    output logic             vec_valid,
    input  logic             vec_ready,
    output logic [VEC_W-1:0] vec,
    output logic             done
`ifdef SCT_ACT_CNT_EN
    ,
    output logic [ACT_W-1:0] act_cnt
`endif
);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [REM_W-1:0] rem;
    logic [CFG_W-1:0] cfg;
    logic             hs_c;

    assign hs_c = vec_valid & vec_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            vec_valid <= 1'b0;
            done      <= 1'b0;
            vec       <= '0;
            cnt       <= '0;
            rem       <= '0;
            cfg       <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        cnt   <= seed;
                        rem   <= (len == 8'd0) ? REM_W'(256) : REM_W'(len);
                        cfg   <= ctrl;
                        busy  <= 1'b1;
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    vec       <= pack_vec(cfg, cnt);
                    vec_valid <= 1'b1;
                    state     <= RUN;
                end
                RUN: begin
                    // Last handshake leaves vec untouched and drops valid.
                    if (hs_c) begin
                        if (rem > REM_W'(1)) begin
                            rem <= rem - REM_W'(1);
                            cnt <= cnt + CNT_W'(1);
                            vec <= pack_vec(cfg, cnt + CNT_W'(1));
                        end else begin
                            vec_valid <= 1'b0;
                            done      <= 1'b1;
                            state     <= DONE;
                        end
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SCT_ACT_CNT_EN
    logic cap_c;

    assign cap_c = (state == IDLE) & start;

    sct_toggle_cnt u_toggle_cnt (
        .clk     (clk),
        .rst     (rst),
        .clr     (cap_c),
        .acc     (hs_c),
        .vec     (vec),
        .act_cnt (act_cnt)
    );
`endif

endmodule
